// File: rtl/l9_pkg.sv
// Shared layer-9 definitions: default geometry, writer FSM encoding and the
// saturating adder used by the write-back stage.
package l9_pkg;

  localparam int L9_DW     = 16;
  localparam int L9_MAP    = 8;
  localparam int L9_CH     = 16;
  localparam int L9_ADDR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } l9_state_e;

  // Operands arrive sign-extended to 32 bits; the sum is formed one bit wider
  // and clamped to the signed range of a dw-bit word (dw <= 31).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned dw);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (dw - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (dw - 1));
    if (s > hi) begin
      return hi[31:0];
    end else if (s < lo) begin
      return lo[31:0];
    end
    return s[31:0];
  endfunction

endpackage

// File: rtl/l9_xyz_counter.sv
// Raster x/y/z counter (x fastest, then y, then channel z) producing the
// linear tensor address and a flag marking the final element of a pass.
module l9_xyz_counter
  import l9_pkg::*;
#(
  parameter int MAP    = L9_MAP,
  parameter int CH     = L9_CH,
  parameter int ADDR_W = L9_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int XW = (MAP > 1) ? $clog2(MAP) : 1;
  localparam int ZW = (CH > 1) ? $clog2(CH) : 1;

  logic [XW-1:0] x;
  logic [XW-1:0] y;
  logic [ZW-1:0] z;

  logic x_max;
  logic y_max;
  logic z_max;

  assign x_max = (x == XW'(MAP - 1));
  assign y_max = (y == XW'(MAP - 1));
  assign z_max = (z == ZW'(CH - 1));
  assign last  = x_max & y_max & z_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
      z <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
      z <= '0;
    end else if (en) begin
      if (x_max) begin
        x <= '0;
        if (y_max) begin
          y <= '0;
          z <= z_max ? '0 : z + ZW'(1);
        end else begin
          y <= y + XW'(1);
        end
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign addr = ADDR_W'(z) * ADDR_W'(MAP * MAP) + ADDR_W'(y) * ADDR_W'(MAP) + ADDR_W'(x);

endmodule

// File: rtl/l9_out_writer.sv
// Layer-9 write-back: accepts conv results, adds the skip operand, saturates,
// optionally applies ReLU and writes each word to the output BRAM in raster order.
module l9_out_writer
  import l9_pkg::*;
#(
  parameter int DW      = L9_DW,
  parameter int MAP     = L9_MAP,
  parameter int CH      = L9_CH,
  parameter int ADDR_W  = L9_ADDR_W,
  parameter int SKIP_EN = 1,
  parameter int RELU_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DW-1:0]     in_data,
  output logic                     in_ready,
  output logic [ADDR_W-1:0]        skip_rd_addr,
  input  logic signed [DW-1:0]     skip_rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DW-1:0]            wr_data,
  output logic                     busy,
  output logic                     done
);

  l9_state_e state;
  l9_state_e state_next;

  logic                 xfer;
  logic                 last_elem;
  logic                 v1;
  logic signed [DW-1:0] d1;
  logic [ADDR_W-1:0]    a1;
  logic signed [31:0]   sum32;
  logic [DW-1:0]        res;

  assign in_ready = (state == ST_RUN);
  assign busy     = (state == ST_RUN) || (state == ST_FLUSH);
  assign done     = (state == ST_DONE);
  assign xfer     = in_valid & in_ready;

  // The counter address doubles as the skip BRAM read address, so the skip
  // word lands exactly when the transferred word reaches stage 1.
  l9_xyz_counter #(
    .MAP    (MAP),
    .CH     (CH),
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start && (state == ST_IDLE)),
    .en   (xfer),
    .addr (skip_rd_addr),
    .last (last_elem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stage 2 drains on the same edge that FLUSH leaves, so only stage 1 gates the exit.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (xfer && last_elem) state_next = ST_FLUSH;
      ST_FLUSH: if (!v1) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      d1 <= '0;
      a1 <= '0;
    end else begin
      v1 <= xfer;
      if (xfer) begin
        d1 <= in_data;
        a1 <= skip_rd_addr;
      end
    end
  end

  always_comb begin
    sum32 = sat_add(32'(d1), (SKIP_EN != 0) ? 32'(skip_rd_data) : 32'sd0, DW);
    res   = sum32[DW-1:0];
    if ((RELU_EN != 0) && res[DW-1]) begin
      res = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= v1;
      if (v1) begin
        wr_addr <= a1;
        wr_data <= res;
      end
    end
  end

endmodule

// File: tb/tb_l9_out_writer.sv
// Self-checking bench for l9_out_writer: two instances (ReLU on/off) share
// stimulus and are compared against a word-indexed reference model.
module tb_l9_out_writer;

  localparam int DW = 16;
  localparam int MAP = 8;
  localparam int CH = 16;
  localparam int AW = 10;
  localparam int N = CH * MAP * MAP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 start;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;

  logic                 in_ready_a, in_ready_b;
  logic [AW-1:0]        skip_addr_a, skip_addr_b;
  logic signed [DW-1:0] skip_q_a, skip_q_b;
  logic                 wr_en_a, wr_en_b;
  logic [AW-1:0]        wr_addr_a, wr_addr_b;
  logic [DW-1:0]        wr_data_a, wr_data_b;
  logic                 busy_a, busy_b;
  logic                 done_a, done_b;

  logic signed [DW-1:0] skip_mem [N];

  always @(posedge clk) begin
    skip_q_a <= skip_mem[skip_addr_a];
    skip_q_b <= skip_mem[skip_addr_b];
  end

  l9_out_writer #(.DW(DW), .MAP(MAP), .CH(CH), .ADDR_W(AW), .SKIP_EN(1), .RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .skip_rd_addr(skip_addr_a), .skip_rd_data(skip_q_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .busy(busy_a), .done(done_a)
  );

  l9_out_writer #(.DW(DW), .MAP(MAP), .CH(CH), .ADDR_W(AW), .SKIP_EN(1), .RELU_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .skip_rd_addr(skip_addr_b), .skip_rd_data(skip_q_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .busy(busy_b), .done(done_b)
  );

  typedef struct {
    int          due;
    int          addr;
    logic [15:0] d_relu;
    logic [15:0] d_raw;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   run_from = -1;
  int   last_xfer = -1;
  int   accepted = 0;
  int   writes_seen = 0;
  int   passes_done = 0;

  function automatic int ref_val(int d, int s, bit relu);
    int v;
    v = d + s;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    if (relu && v < 0) v = 0;
    return v;
  endfunction

  function automatic bit model_ready();
    return (run_from >= 0) && (cyc >= run_from) && (accepted < N);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Compare every visible output against the model for the current cycle.
  task automatic check_cycle();
    bit exp_busy;
    bit exp_done;
    exp_t e;
    exp_busy = (run_from >= 0) && (cyc >= run_from) && (last_xfer < 0 || cyc <= last_xfer + 2);
    exp_done = (last_xfer >= 0) && (cyc == last_xfer + 3);
    check_output("in_ready", in_ready_a, model_ready());
    check_output("busy", busy_a, exp_busy);
    check_output("done", done_a, exp_done);
    check_output("done_nr", done_b, exp_done);
    check_output("skip_rd_addr", skip_addr_a, accepted % N);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check_output("wr_en", wr_en_a, 1);
      check_output("wr_addr", wr_addr_a, e.addr);
      check_output("wr_data_relu", wr_data_a, e.d_relu);
      check_output("wr_en_nr", wr_en_b, 1);
      check_output("wr_data_raw", wr_data_b, e.d_raw);
      writes_seen++;
    end else begin
      check_output("wr_en_idle", wr_en_a, 0);
      check_output("wr_en_idle_nr", wr_en_b, 0);
    end
    if (last_xfer >= 0 && cyc == last_xfer + 4) begin
      run_from = -1;
      last_xfer = -1;
      passes_done++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic apply_stimulus(input bit v, input logic signed [15:0] d, input bit st);
    exp_t e;
    in_valid = v;
    in_data  = d;
    start    = st;
    if (v && model_ready()) begin
      e.due    = cyc + 2;
      e.addr   = accepted;
      e.d_relu = 16'(ref_val(int'(d), int'(skip_mem[accepted]), 1'b1));
      e.d_raw  = 16'(ref_val(int'(d), int'(skip_mem[accepted]), 1'b0));
      exp_q.push_back(e);
      accepted++;
      if (accepted == N) last_xfer = cyc;
    end
    if (st && run_from < 0) begin
      run_from = cyc + 1;
      accepted = 0;
    end
    tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    start    = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_output("rst_wr_en", wr_en_a, 0);
    check_output("rst_busy", busy_a, 0);
    check_output("rst_in_ready", in_ready_a, 0);
    exp_q.delete();
    run_from = -1;
    last_xfer = -1;
    accepted = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  function automatic logic signed [15:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 16'sh7FFF;
      1: return 16'sh8000;
      2: return 16'(-$urandom_range(0, 300));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_pass(input bit rnd, input bit bubbles, input int reset_at);
    int base;
    int w0;
    bit v;
    bit st;
    logic signed [15:0] d;
    base = passes_done;
    w0 = writes_seen;
    for (int k = 0; k < 3000 && passes_done == base; k++) begin
      v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      d  = rnd ? rand_word() : 16'sd1;
      st = (k == 0) || (k == 100) || (last_xfer >= 0 && cyc == last_xfer + 1);
      if (bubbles && k >= 1 && k <= 4) v = (k == 1) || (k == 4);
      if (bubbles && accepted == 0) d = 16'sh7FF0;
      if (bubbles && accepted == 1) d = 16'sh8000;
      if (k == 0) v = 1'b1;
      apply_stimulus(v, d, st);
      if (reset_at > 0 && writes_seen - w0 == reset_at) begin
        do_reset();
        return;
      end
    end
    if (passes_done == base) check_output("pass_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    for (int i = 0; i < N; i++) skip_mem[i] = 16'sd2;
    #2;
    $display("[TB] reset state");
    check_output("reset_in_ready", in_ready_a, 0);
    check_output("reset_wr_en", wr_en_a, 0);
    check_output("reset_busy", busy_a, 0);
    check_output("reset_done", done_a, 0);
    check_output("reset_wr_addr", wr_addr_a, 0);
    check_output("reset_wr_data", wr_data_a, 0);
    check_output("reset_skip_addr", skip_addr_a, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] full pass, data=1 skip=2, stray starts");
    run_pass(1'b0, 1'b0, 0);
    tick();

    $display("[TB] saturation, relu and bubbles");
    for (int i = 0; i < N; i++) skip_mem[i] = rand_word();
    skip_mem[0] = 16'sh0100;
    skip_mem[1] = 16'shFFFF;
    run_pass(1'b1, 1'b1, 0);

    $display("[TB] async reset at write 500");
    run_pass(1'b1, 1'b0, 500);

    $display("[TB] fresh pass after reset");
    run_pass(1'b1, 1'b0, 0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
